// File: rtl/bs_alu_seq_if.sv
// Control/data bundle between the bit-serial ALU sequencer and its neighbours:
// start/op request, serial operand bits in, register file controls and flags out.
interface bs_alu_seq_if;
    logic       i_start;
    logic [1:0] i_op;
    logic       i_dst;
    logic       i_a_bit;
    logic       i_b_bit;
    logic       o_rd_addr;
    logic       o_shift;
    logic       o_sign_sel;
    logic       o_res_bit;
    logic       o_sign_bit;
    logic       o_busy;
    logic       o_done;
    logic       o_carry;
    logic       o_zero;
    logic       o_ovf;

    modport slave (
        input  i_start, i_op, i_dst, i_a_bit, i_b_bit,
        output o_rd_addr, o_shift, o_sign_sel, o_res_bit, o_sign_bit,
        output o_busy, o_done, o_carry, o_zero, o_ovf
    );

    modport master (
        output i_start, i_op, i_dst, i_a_bit, i_b_bit,
        input  o_rd_addr, o_shift, o_sign_sel, o_res_bit, o_sign_bit,
        input  o_busy, o_done, o_carry, o_zero, o_ovf
    );
endinterface

// File: rtl/bs_alu_seq.sv
// Bit-serial ALU sequencer: reads operand A from the register file LSB-first, combines it
// with serial operand B and writes the result back into the same entry one bit per clock.
module bs_alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic         i_clk,
    input logic         i_rst,
    bs_alu_seq_if.slave bus
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StExt, StDone} state_e;
    typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpAsr = 2'b10, OpXor = 2'b11} op_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    op_e             op_q, op_d;
    logic            dst_q, dst_d;
    logic            zero_acc_q, zero_acc_d;
    logic            msb_q, msb_d;
    logic            carry_flag_q, carry_flag_d;
    logic            zero_flag_q, zero_flag_d;
    logic            ovf_flag_q, ovf_flag_d;

    logic b_eff, sum_bit, carry_nxt, res_bit, is_addsub;
    logic shift, sign_sel, sign_bit, run_bit, busy, done;

    // SUB is A + ~B + 1: B is inverted per bit and the carry is preset to 1 at start.
    always_comb begin
        is_addsub = (op_q == OpAdd) || (op_q == OpSub);
        b_eff     = (op_q == OpSub) ? ~bus.i_b_bit : bus.i_b_bit;
        sum_bit   = bus.i_a_bit ^ b_eff ^ carry_q;
        carry_nxt = (bus.i_a_bit & b_eff) | (bus.i_a_bit & carry_q) | (b_eff & carry_q);
        unique case (op_q)
            OpAdd, OpSub: res_bit = sum_bit;
            OpAsr:        res_bit = bus.i_a_bit;
            default:      res_bit = bus.i_a_bit ^ bus.i_b_bit;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        op_d         = op_q;
        dst_d        = dst_q;
        zero_acc_d   = zero_acc_q;
        msb_d        = msb_q;
        carry_flag_d = carry_flag_q;
        zero_flag_d  = zero_flag_q;
        ovf_flag_d   = ovf_flag_q;
        shift        = 1'b0;
        sign_sel     = 1'b0;
        sign_bit     = 1'b0;
        run_bit      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    op_d       = op_e'(bus.i_op);
                    dst_d      = bus.i_dst;
                    carry_d    = (op_e'(bus.i_op) == OpSub);
                    zero_acc_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                shift   = 1'b1;
                run_bit = res_bit;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CntW'(1);
                // ASR's bit 0 falls off the end, so it must not affect the zero flag.
                if (!(op_q == OpAsr && cnt_q == '0)) begin
                    zero_acc_d = zero_acc_q & ~res_bit;
                end
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (op_q == OpAsr) begin
                        msb_d   = bus.i_a_bit;
                        state_d = StExt;
                    end else begin
                        carry_flag_d = is_addsub & carry_nxt;
                        ovf_flag_d   = is_addsub & (carry_q ^ carry_nxt);
                        zero_flag_d  = zero_acc_q & ~res_bit;
                        state_d      = StDone;
                    end
                end
            end
            StExt: begin
                busy         = 1'b1;
                shift        = 1'b1;
                sign_sel     = 1'b1;
                sign_bit     = msb_q;
                carry_flag_d = 1'b0;
                ovf_flag_d   = 1'b0;
                zero_flag_d  = zero_acc_q;
                state_d      = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            op_q         <= OpAdd;
            dst_q        <= 1'b0;
            zero_acc_q   <= 1'b0;
            msb_q        <= 1'b0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
            ovf_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            op_q         <= op_d;
            dst_q        <= dst_d;
            zero_acc_q   <= zero_acc_d;
            msb_q        <= msb_d;
            carry_flag_q <= carry_flag_d;
            zero_flag_q  <= zero_flag_d;
            ovf_flag_q   <= ovf_flag_d;
        end
    end

    assign bus.o_rd_addr  = dst_q;
    assign bus.o_shift    = shift;
    assign bus.o_sign_sel = sign_sel;
    assign bus.o_res_bit  = run_bit;
    assign bus.o_sign_bit = sign_bit;
    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
    assign bus.o_carry    = carry_flag_q;
    assign bus.o_zero     = zero_flag_q;
    assign bus.o_ovf      = ovf_flag_q;

endmodule

// File: tb/tb_bs_alu_seq.sv
// Bench for bs_alu_seq: models the downstream two-entry register file and the serial B
// source, and checks results, flags and handshake timing against an arithmetic model.
module tb_bs_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bs_alu_seq_if bus ();

    bs_alu_seq #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Register file and B shifter, loaded through ld_* from the stimulus process.
    logic [W-1:0] rf [2];
    logic [W-1:0] b_sh;
    logic         ld_en;
    logic         ld_addr;
    logic [W-1:0] ld_a, ld_b, ld_o;

    always @(posedge clk) begin
        if (ld_en) begin
            rf[ld_addr]  <= ld_a;
            rf[!ld_addr] <= ld_o;
            b_sh         <= ld_b;
        end else if (bus.o_shift) begin
            if (bus.o_sign_sel)
                rf[bus.o_rd_addr] <= {bus.o_sign_bit, rf[bus.o_rd_addr][W-1:1]};
            else
                rf[bus.o_rd_addr] <= {bus.o_res_bit, rf[bus.o_rd_addr][W-1:1]};
            b_sh <= {1'b0, b_sh[W-1:1]};
        end
    end

    assign bus.i_a_bit = rf[bus.o_rd_addr][0];
    assign bus.i_b_bit = b_sh[0];

    function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] r,
                                      output logic c, output logic z, output logic v);
        int sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            2'd0: begin
                r  = W'(int'(a) + int'(b));
                c  = (int'(a) + int'(b)) > 255;
                sr = sa + sb;
                v  = (sr > 127) || (sr < -128);
            end
            2'd1: begin
                r  = W'(int'(a) - int'(b));
                c  = a >= b;
                sr = sa - sb;
                v  = (sr > 127) || (sr < -128);
            end
            2'd2: r = W'($signed(a) >>> 1);
            default: r = a ^ b;
        endcase
        z = (r == '0);
    endfunction

    task automatic load(input logic dst, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] other);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = dst; ld_a = a; ld_b = b; ld_o = other;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one operation; glitch=1 pulses i_start with a SUB request mid-RUN.
    task automatic run_op(input string name, input logic [1:0] op, input logic dst,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch);
        logic [W-1:0] exp_r, other;
        logic         ec, ez, ev;
        int           cyc, shifts, done_cyc, exp_done, exp_shifts;
        logic [31:0]  sel_mask, exp_sel;
        bit           busy_bad;

        ref_model(op, a, b, exp_r, ec, ez, ev);
        other = W'($urandom);
        load(dst, a, b, other);
        bus.i_start = 1'b1; bus.i_op = op; bus.i_dst = dst;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_op = W'($urandom) % 4;
        bus.i_dst = !dst;
        cyc = 1; shifts = 0; done_cyc = 0; sel_mask = '0; busy_bad = 0;
        while (cyc <= W + 6) begin
            if (bus.o_shift) shifts++;
            if (bus.o_sign_sel) sel_mask[cyc] = 1'b1;
            if (bus.o_done) begin
                done_cyc = cyc;
                if (bus.o_busy) busy_bad = 1;
                break;
            end
            if (!bus.o_busy) busy_bad = 1;
            if (glitch && cyc == 3) begin
                bus.i_start = 1'b1; bus.i_op = 2'b01;
            end else begin
                bus.i_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.i_start = 1'b0;
        exp_done   = (op == 2'd2) ? W + 2 : W + 1;
        exp_shifts = (op == 2'd2) ? W + 1 : W;
        exp_sel    = (op == 2'd2) ? (32'd1 << (W + 1)) : 32'd0;

        checks++;
        if (done_cyc !== exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (shifts !== exp_shifts) begin
            errors++;
            $display("FAIL %s shift_count: got %0d want %0d", name, shifts, exp_shifts);
        end
        checks++;
        if (sel_mask !== exp_sel) begin
            errors++;
            $display("FAIL %s sign_sel_cycles: got %h want %h", name, sel_mask, exp_sel);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s busy: got irregular want high in RUN/EXT only", name);
        end
        checks++;
        if (rf[dst] !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, rf[dst], exp_r);
        end
        checks++;
        if (rf[!dst] !== other) begin
            errors++;
            $display("FAIL %s other_entry: got %h want %h", name, rf[!dst], other);
        end
        checks++;
        if ({bus.o_carry, bus.o_zero, bus.o_ovf} !== {ec, ez, ev}) begin
            errors++;
            $display("FAIL %s flags_czv: got %b%b%b want %b%b%b", name,
                     bus.o_carry, bus.o_zero, bus.o_ovf, ec, ez, ev);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_shift} !== 3'b000) begin
            errors++;
            $display("FAIL %s after_done: got done/busy/shift=%b%b%b want 000", name,
                     bus.o_done, bus.o_busy, bus.o_shift);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.o_rd_addr, bus.o_shift, bus.o_sign_sel, bus.o_res_bit, bus.o_sign_bit,
             bus.o_busy, bus.o_done, bus.o_carry, bus.o_zero, bus.o_ovf} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero want all 0");
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_shift, bus.o_busy, bus.o_done, bus.o_carry, bus.o_zero, bus.o_ovf}
            !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got nonzero want all 0");
        end
    endtask

    task automatic test_add();
        run_op("add_5a_3c", 2'd0, 1'b0, 8'h5A, 8'h3C, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_equal", 2'd1, 1'b1, 8'h10, 8'h10, 1'b0);
        run_op("sub_borrow", 2'd1, 1'b0, 8'h00, 8'h01, 1'b0);
    endtask

    task automatic test_asr();
        run_op("asr_84", 2'd2, 1'b1, 8'h84, 8'h5A, 1'b0);
        run_op("asr_01", 2'd2, 1'b0, 8'h01, 8'hFF, 1'b0);
    endtask

    task automatic test_xor_hold();
        run_op("xor_ff", 2'd3, 1'b1, 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.o_carry, bus.o_zero, bus.o_ovf} !== 3'b010) begin
                errors++;
                $display("FAIL flag_hold[%0d]: got %b%b%b want 010", i,
                         bus.o_carry, bus.o_zero, bus.o_ovf);
            end
        end
    endtask

    task automatic test_start_ignored();
        run_op("add_glitch", 2'd0, 1'b0, 8'h5A, 8'h3C, 1'b1);
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] snap;
        int           late_shifts;
        run_op("sub_pre_abort", 2'd1, 1'b1, 8'h10, 8'h10, 1'b0);
        load(1'b1, 8'h5A, 8'h3C, 8'h00);
        bus.i_start = 1'b1; bus.i_op = 2'd0; bus.i_dst = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        snap = rf[1];
        checks++;
        if ({bus.o_shift, bus.o_busy, bus.o_done, bus.o_carry, bus.o_zero, bus.o_ovf}
            !== 6'b0) begin
            errors++;
            $display("FAIL abort_outputs: got shift/busy/done/c/z/v=%b%b%b%b%b%b want 000000",
                     bus.o_shift, bus.o_busy, bus.o_done, bus.o_carry, bus.o_zero, bus.o_ovf);
        end
        late_shifts = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.o_shift) late_shifts++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_shift || bus.o_busy) late_shifts++;
        end
        checks++;
        if (late_shifts !== 0 || rf[1] !== snap) begin
            errors++;
            $display("FAIL abort_idle: got activity=%0d entry=%h want 0 entry=%h",
                     late_shifts, rf[1], snap);
        end
        run_op("add_after_abort", 2'd0, 1'b0, 8'h01, 8'h01, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        ld_en = 1'b0; ld_addr = 1'b0; ld_a = '0; ld_b = '0; ld_o = '0;
        bus.i_start = 1'b0; bus.i_op = 2'd0; bus.i_dst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_asr();
        test_xor_hold();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bs_alu_seq.md
# bs_alu_seq

Bit-serial ALU sequencer that drives the two-entry bit-serial register file directly downstream of it. It takes operand A LSB-first from the register file's serial output and operand B from an external serial source. It computes the result one bit per clock and drives the register file's shift, data and sign-insert controls so the result is written back into the entry being read. It owns the bit counter, the carry flip-flop, the start/busy/done handshake and the result flags.

## Interface
- WIDTH, 8, operand/result width in bits (= register file entry width)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start request, sampled only in IDLE
- i_op  in  2  operation, latched at start: 00 ADD, 01 SUB (A-B), 10 ASR (A>>>1), 11 XOR
- i_dst  in  1  register file entry, latched at start
- i_a_bit  in  1  operand A current LSB (register file serial output)
- i_b_bit  in  1  operand B current LSB, LSB-first, advanced externally on o_shift
- o_rd_addr  out  1  latched i_dst, to register file rd_addr
- o_shift  out  1  to register file shift enable
- o_sign_sel  out  1  to register file sign-select
- o_res_bit  out  1  result bit, to register file serial data input
- o_sign_bit  out  1  sign bit, to register file sign data input
- o_busy  out  1  operation in progress
- o_done  out  1  one-cycle completion pulse
- o_carry, o_zero, o_ovf  out  1 each  result flags

## Operation
- States:
  - IDLE: o_busy=0. i_start=1 latches i_op, i_dst, initialises carry (1 for SUB, else 0) and zero-accumulator (1), clears the counter, and moves to RUN.
  - RUN: o_busy=1, o_shift=1. Runs WIDTH cycles, counter 0..WIDTH-1. At count WIDTH-1, moves to EXT if op=ASR, else to DONE.
  - EXT: ASR only, one cycle. o_busy=1, o_shift=1, o_sign_sel=1, o_sign_bit=captured MSB. Moves to DONE.
  - DONE: one cycle. o_done=1, o_busy=0. Flags update on entry. Moves to IDLE.
- Result bit in RUN, combinational from inputs and registered carry:
  - ADD: a^b^c. Carry next = majority(a,b,c).
  - SUB: a^~b^c. Carry next = majority(a,~b,c).
  - ASR: a (rotate pass). The bit at count WIDTH-1 is captured as MSB. The EXT cycle then shifts once more, inserting the MSB, so the entry holds {a[7],a[7:1]}.
  - XOR: a^b.
- o_sign_sel=0 and o_sign_bit=0 outside EXT.
- Flags are held from DONE until the next DONE; reset value 0.
  - o_carry: final carry-out for ADD/SUB (SUB: 1 = no borrow); 0 for ASR/XOR.
  - o_ovf: carry into MSB XOR carry out of MSB for ADD/SUB; 0 otherwise.
  - o_zero: 1 iff every result bit is 0. For ASR, computed over RUN bits 1..WIDTH-1, since the result is {a[7],a[7:1]}.
- i_start outside IDLE, including DONE, is ignored. i_op and i_dst changes during an operation have no effect.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE, counter 0, carry 0, latched op/dst 0
- Reset mid-operation aborts immediately: o_shift drops asynchronously and no further shifts occur.
- Start accepted at edge E0:
  - RUN occupies cycles E0..E0+WIDTH (o_shift asserted for WIDTH consecutive cycles).
  - ADD/SUB/XOR: o_done high in cycle E0+WIDTH, i.e. done visible WIDTH+1 cycles after start. Total shifts = WIDTH.
  - ASR: EXT adds one cycle. Done visible WIDTH+2 cycles after start. Total shifts = WIDTH+1.
- Each shift edge advances i_a_bit. i_b_bit must present the next bit before the following edge. Result bits are consumed at the same edge they are produced (no pipeline).
- The earliest next start is the cycle after o_done, when the state is IDLE.

## Test plan
- ADD A=0x5A, B=0x3C -> entry 0x96; o_carry=0, o_ovf=1, o_zero=0; exactly 8 shift cycles; o_done one cycle.
- SUB A=0x10, B=0x10 -> entry 0x00; o_carry=1, o_zero=1, o_ovf=0. SUB A=0x00, B=0x01 -> 0xFF, o_carry=0.
- ASR A=0x84 -> entry 0xC2, o_zero=0; 9 shift cycles, o_sign_sel high only in cycle 9. ASR A=0x01 -> 0x00, o_zero=1.
- XOR A=0xFF, B=0xFF -> 0x00, o_zero=1, o_carry=0. Flags then held unchanged through 5 idle cycles.
- Pulse i_start during RUN with op=SUB -> ignored: the current ADD result, shift count and done timing are unchanged.
- Assert i_rst at RUN count 4 -> o_shift, o_busy and flags go 0 immediately, state IDLE. A new ADD 0x01+0x01 after release -> 0x02.
